// File: rtl/ntt_job_ctrl.sv
// ntt_job_ctrl -- job sequencer for an NTT/INTT datapath.
//
// Two requesters compete for the shared transform engine. A round-robin
// arbiter picks one winner. The controller pulses ag_start to the address
// generator and waits for ag_done. An INTT job also runs an N-cycle n^-1
// scale pass. The winner then gets a job_done pulse. If ag_done does not
// arrive within TIMEOUT RUN cycles, job_done is pulsed together with job_err.
//
// Ports
//   clk        : single clock; all state changes on its rising edge
//   rst        : asynchronous, active-low reset
//   req[1:0]   : per-requester job request
//   req_sel    : per-requester mode (0 NTT, 1 INTT); sampled with the grant
//   gnt        : one-hot grant, held from LAUNCH through FIN/ERR
//   busy       : high whenever the controller is not idle
//   ag_start   : one-cycle start pulse to the address generator
//   ag_sel     : mode to the address generator, stable for the whole job
//   ag_done    : address-generator completion pulse
//   scale_en   : high during the INTT scale pass
//   scale_addr : coefficient address during the scale pass, else 0
//   job_done   : one-cycle completion pulse to the granted requester
//   job_err    : one-cycle pulse alongside job_done when the job timed out
//
// All outputs are flops computed from the next state, so they change on the
// same edge as the state. No input has a combinational path to an output.
module ntt_job_ctrl #(
    parameter int N       = 256,
    parameter int TIMEOUT = 2048
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] req_sel,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       ag_start,
    output logic       ag_sel,
    input  logic       ag_done,
    output logic       scale_en,
    output logic [7:0] scale_addr,
    output logic [1:0] job_done,
    output logic       job_err
);

    localparam int               CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [7:0]       ADDR_LAST = 8'(N - 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        RUN,
        SCALE,
        FIN,
        ERR
    } state_e;

    state_e           state_q, state_d;
    logic             winner_q, winner_d;     // index of the granted requester
    logic             sel_q, sel_d;           // mode latched at grant time
    logic             prio_q, prio_d;         // requester that wins a tie
    logic [CNT_W-1:0] cnt_q, cnt_d;           // RUN-cycle timeout counter
    logic [1:0]       gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic             ag_start_q, ag_start_d;
    logic             ag_sel_q, ag_sel_d;
    logic             scale_en_q, scale_en_d;
    logic [7:0]       scale_addr_q, scale_addr_d;
    logic [1:0]       job_done_q, job_done_d;
    logic             job_err_q, job_err_d;
    logic             pick;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d      = state_q;
        winner_d     = winner_q;
        sel_d        = sel_q;
        prio_d       = prio_q;
        cnt_d        = '0;
        scale_addr_d = '0;
        pick         = 1'b0;

        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    // A tie goes to prio_q; a lone request wins outright.
                    pick     = (req == 2'b11) ? prio_q : req[1];
                    winner_d = pick;
                    sel_d    = req_sel[pick];
                    prio_d   = ~pick;
                    state_d  = LAUNCH;
                end
            end
            // ag_done is deliberately not looked at here.
            LAUNCH: state_d = RUN;
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                // A done arriving on the last allowed cycle still counts as success.
                if (ag_done) begin
                    state_d = sel_q ? SCALE : FIN;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ERR;
                end
            end
            SCALE: begin
                // Entry from RUN leaves scale_addr_d at its default 0.
                if (scale_addr_q == ADDR_LAST) begin
                    state_d = FIN;
                end else begin
                    scale_addr_d = scale_addr_q + 8'd1;
                end
            end
            FIN:     state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are derived from the next state so that they are registered.
        busy_d     = (state_d != IDLE);
        gnt_d      = busy_d ? {winner_d, ~winner_d} : 2'b00;
        ag_start_d = (state_d == LAUNCH);
        ag_sel_d   = busy_d & sel_d;
        scale_en_d = (state_d == SCALE);
        job_done_d = ((state_d == FIN) || (state_d == ERR)) ? {winner_d, ~winner_d} : 2'b00;
        job_err_d  = (state_d == ERR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            winner_q     <= 1'b0;
            sel_q        <= 1'b0;
            prio_q       <= 1'b0;
            cnt_q        <= '0;
            gnt_q        <= 2'b00;
            busy_q       <= 1'b0;
            ag_start_q   <= 1'b0;
            ag_sel_q     <= 1'b0;
            scale_en_q   <= 1'b0;
            scale_addr_q <= 8'd0;
            job_done_q   <= 2'b00;
            job_err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every flop samples pre-edge values.
            state_q      <= state_d;
            winner_q     <= winner_d;
            sel_q        <= sel_d;
            prio_q       <= prio_d;
            cnt_q        <= cnt_d;
            gnt_q        <= gnt_d;
            busy_q       <= busy_d;
            ag_start_q   <= ag_start_d;
            ag_sel_q     <= ag_sel_d;
            scale_en_q   <= scale_en_d;
            scale_addr_q <= scale_addr_d;
            job_done_q   <= job_done_d;
            job_err_q    <= job_err_d;
        end
    end

    assign gnt        = gnt_q;
    assign busy       = busy_q;
    assign ag_start   = ag_start_q;
    assign ag_sel     = ag_sel_q;
    assign scale_en   = scale_en_q;
    assign scale_addr = scale_addr_q;
    assign job_done   = job_done_q;
    assign job_err    = job_err_q;

endmodule

// File: tb/tb_ntt_job_ctrl.sv
// Testbench for ntt_job_ctrl.
// The reference model works at job level. A "last served" record decides
// the expected winner. The expected cycle of every observable event is
// computed by arithmetic from the ag_start cycle and the ag_done delay.
module tb_ntt_job_ctrl;

    localparam int N       = 256;
    localparam int TIMEOUT = 2048;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [1:0] req_sel;
    logic [1:0] gnt;
    logic       busy;
    logic       ag_start;
    logic       ag_sel;
    logic       ag_done;
    logic       scale_en;
    logic [7:0] scale_addr;
    logic [1:0] job_done;
    logic       job_err;

    int checks      = 0;
    int errors      = 0;
    int last_served = -1;   // -1: nobody served since reset

    ntt_job_ctrl #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_sel    (req_sel),
        .gnt        (gnt),
        .busy       (busy),
        .ag_start   (ag_start),
        .ag_sel     (ag_sel),
        .ag_done    (ag_done),
        .scale_en   (scale_en),
        .scale_addr (scale_addr),
        .job_done   (job_done),
        .job_err    (job_err)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Advance one edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: a lone requester wins. On a tie the requester not
    // served last wins, and requester 0 wins if nobody has been served yet.
    function automatic int pick(input logic [1:0] rq);
        if (rq == 2'b01) return 0;
        if (rq == 2'b10) return 1;
        return (last_served == 0) ? 1 : 0;
    endfunction

    // Issue one job and follow it cycle by cycle to the return to IDLE.
    // The address generator answers 'delay' cycles after start, or never if timeout=1.
    // toggle scrambles req/req_sel while busy; spurious pulses ag_done during LAUNCH.
    task automatic run_job(input logic [1:0] rq, input logic [1:0] rs, input int delay,
                           input bit timeout, input bit toggle, input bit spurious,
                           input string tag, output logic [1:0] launch_gnt);
        int         w;
        logic       s;
        logic [1:0] oh;
        int         done_t;
        logic       exp_scale;
        logic [7:0] exp_addr;
        logic [1:0] exp_done;
        logic       exp_err;

        w      = pick(rq);
        s      = rs[w];
        oh     = (w == 1) ? 2'b10 : 2'b01;
        done_t = timeout ? TIMEOUT + 1 : (s ? delay + 1 + N : delay + 1);

        req     = rq;
        req_sel = rs;
        ag_done = 1'b0;
        tick();
        launch_gnt = gnt;
        checks++;
        if (ag_start !== 1'b1 || gnt !== oh || ag_sel !== s || busy !== 1'b1 || job_done !== 2'b00) begin
            errors++;
            $display("FAIL %s launch: ag_start=%b gnt=%b ag_sel=%b busy=%b job_done=%b, want 1 %b %b 1 00",
                     tag, ag_start, gnt, ag_sel, busy, job_done, oh, s);
        end
        last_served = w;

        for (int t = 1; t <= done_t; t++) begin
            ag_done = (!timeout && t == delay + 1) || (spurious && t == 1);
            if (toggle) begin
                req     = 2'($urandom);
                req_sel = 2'($urandom);
            end
            tick();
            exp_scale = s && !timeout && (t >= delay + 1) && (t <= delay + N);
            exp_addr  = exp_scale ? 8'(t - delay - 1) : 8'd0;
            exp_done  = (t == done_t) ? oh : 2'b00;
            exp_err   = timeout && (t == done_t);

            checks++;
            if (gnt !== oh || busy !== 1'b1 || ag_start !== 1'b0 || ag_sel !== s) begin
                errors++;
                $display("FAIL %s hold t=%0d: gnt=%b busy=%b ag_start=%b ag_sel=%b, want %b 1 0 %b",
                         tag, t, gnt, busy, ag_start, ag_sel, oh, s);
            end
            checks++;
            if (scale_en !== exp_scale || scale_addr !== exp_addr) begin
                errors++;
                $display("FAIL %s scale t=%0d: scale_en=%b scale_addr=%0d, want %b %0d",
                         tag, t, scale_en, scale_addr, exp_scale, exp_addr);
            end
            checks++;
            if (job_done !== exp_done || job_err !== exp_err) begin
                errors++;
                $display("FAIL %s done t=%0d: job_done=%b job_err=%b, want %b %b",
                         tag, t, job_done, job_err, exp_done, exp_err);
            end
        end

        ag_done = 1'b0;
        req     = 2'b00;
        tick();
        checks++;
        if ({gnt, busy, ag_start, ag_sel, scale_en, scale_addr, job_done, job_err} !== 17'd0) begin
            errors++;
            $display("FAIL %s idle: gnt=%b busy=%b ag_start=%b ag_sel=%b scale_en=%b job_done=%b job_err=%b, want all 0",
                     tag, gnt, busy, ag_start, ag_sel, scale_en, job_done, job_err);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        last_served = -1;
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        req     = 2'b11;
        req_sel = 2'b11;
        ag_done = 1'b1;
        repeat (3) tick();
        checks++;
        if ({gnt, busy, ag_start, ag_sel, scale_en, scale_addr, job_done, job_err} !== 17'd0) begin
            errors++;
            $display("FAIL reset: gnt=%b busy=%b ag_start=%b ag_sel=%b scale_en=%b scale_addr=%0d job_done=%b job_err=%b, want all 0",
                     gnt, busy, ag_start, ag_sel, scale_en, scale_addr, job_done, job_err);
        end
        req     = 2'b00;
        req_sel = 2'b00;
        ag_done = 1'b0;
        rst     = 1'b1;
        last_served = -1;
        tick();
        checks++;
        if (busy !== 1'b0 || gnt !== 2'b00) begin
            errors++;
            $display("FAIL reset_release: busy=%b gnt=%b, want 0 00", busy, gnt);
        end
    endtask

    task automatic test_ntt();
        logic [1:0] g;
        run_job(2'b01, 2'b00, 896, 1'b0, 1'b0, 1'b0, "ntt", g);
    endtask

    task automatic test_intt();
        logic [1:0] g;
        run_job(2'b10, 2'b10, 17, 1'b0, 1'b0, 1'b0, "intt", g);
    endtask

    task automatic test_contention();
        logic [1:0] g;
        logic [1:0] want;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            want = (i % 2 == 1) ? 2'b10 : 2'b01;
            run_job(2'b11, 2'($urandom), int'($urandom_range(1, 30)), 1'b0, 1'b0, 1'b0, "contention", g);
            checks++;
            if (g !== want) begin
                errors++;
                $display("FAIL contention_order job=%0d: gnt=%b, want %b", i, g, want);
            end
        end
    endtask

    task automatic test_timeout();
        logic [1:0] g;
        run_job(2'b01, 2'b00, 0, 1'b1, 1'b0, 1'b0, "timeout", g);
        run_job(2'b10, 2'b00, 5, 1'b0, 1'b0, 1'b0, "after_timeout", g);
    endtask

    task automatic test_spurious_abort();
        logic [1:0] g;
        int         steps;
        bit         found;

        // A done pulse while idle must not wake the controller.
        ag_done = 1'b1;
        tick();
        ag_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (busy !== 1'b0 || ag_start !== 1'b0 || gnt !== 2'b00 || job_done !== 2'b00) begin
                errors++;
                $display("FAIL spurious_idle: busy=%b ag_start=%b gnt=%b job_done=%b, want 0 0 00 00",
                         busy, ag_start, gnt, job_done);
            end
            tick();
        end

        // Start an INTT job and reset it in the middle of the scale pass.
        req     = 2'b10;
        req_sel = 2'b10;
        tick();
        checks++;
        if (ag_start !== 1'b1 || gnt !== 2'b10) begin
            errors++;
            $display("FAIL abort_launch: ag_start=%b gnt=%b, want 1 10", ag_start, gnt);
        end
        last_served = 1;
        req = 2'b00;
        repeat (3) tick();
        ag_done = 1'b1;
        tick();
        ag_done = 1'b0;
        found = 0;
        steps = 0;
        while (!found && steps < N + 4) begin
            if (scale_en === 1'b1 && scale_addr === 8'd100) found = 1;
            else begin
                tick();
                steps++;
            end
        end
        checks++;
        if (!found || steps != 100) begin
            errors++;
            $display("FAIL abort_reach: found=%0d steps=%0d, want 1 100", found, steps);
        end

        rst = 1'b0;
        #1;
        checks++;
        if ({gnt, busy, ag_start, ag_sel, scale_en, scale_addr, job_done, job_err} !== 17'd0) begin
            errors++;
            $display("FAIL abort_outputs: gnt=%b busy=%b ag_sel=%b scale_en=%b scale_addr=%0d job_done=%b, want all 0",
                     gnt, busy, ag_sel, scale_en, scale_addr, job_done);
        end
        repeat (2) begin
            tick();
            checks++;
            if (job_done !== 2'b00 || job_err !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_done: job_done=%b job_err=%b, want 00 0", job_done, job_err);
            end
        end
        rst = 1'b1;
        last_served = -1;
        tick();

        // The first job after reset release arbitrates from scratch: requester 0 wins a tie.
        run_job(2'b11, 2'b01, 7, 1'b0, 1'b0, 1'b0, "post_abort", g);
        checks++;
        if (g !== 2'b01) begin
            errors++;
            $display("FAIL post_abort_grant: gnt=%b, want 01", g);
        end
    endtask

    task automatic test_midjob_change();
        logic [1:0] g;
        run_job(2'b01, 2'b00, 30, 1'b0, 1'b1, 1'b1, "midjob_ntt", g);
        run_job(2'b10, 2'b10, 12, 1'b0, 1'b1, 1'b1, "midjob_intt", g);
    endtask

    task automatic test_random();
        logic [1:0] g;
        for (int i = 0; i < 10; i++) begin
            run_job(2'($urandom_range(1, 3)), 2'($urandom), int'($urandom_range(1, 40)),
                    1'b0, 1'($urandom), 1'($urandom), "random", g);
        end
    endtask

    initial begin
        req     = 2'b00;
        req_sel = 2'b00;
        ag_done = 1'b0;
        rst     = 1'b0;
        test_reset();
        test_ntt();
        test_intt();
        test_contention();
        test_timeout();
        test_spurious_abort();
        test_midjob_change();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ntt_job_ctrl.md
NTT_JOB_CTRL -- requirements
Module: ntt_job_ctrl

Interface
REQ-001 SHALL have parameter N, default 256, meaning the number of coefficients per polynomial and INTT scale-pass length.
REQ-002 SHALL have parameter TIMEOUT, default 2048, meaning the maximum cycles RUN waits for ag_done.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 req  input  2  per-requester job request; bit i belongs to requester i.
REQ-006 req_sel  input  2  per-requester mode (0 NTT, 1 INTT); sampled with the grant.
REQ-007 gnt  output  2  one-hot grant; at most one bit high.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 ag_start  output  1  one-cycle start pulse to addrgen.
REQ-010 ag_sel  output  1  mode to addrgen; held stable from LAUNCH through FIN.
REQ-011 ag_done  input  1  addrgen completion pulse.
REQ-012 scale_en  output  1  high while the INTT n^-1 scale pass is running.
REQ-013 scale_addr  output  8  coefficient address for the scale pass.
REQ-014 job_done  output  2  one-cycle completion pulse to the granted requester.
REQ-015 job_err  output  1  one-cycle pulse, coincident with job_done, when the job timed out.

Function
REQ-016 SHALL register all outputs; no combinational path from input to output.
REQ-017 SHALL use FSM states IDLE, LAUNCH, RUN, SCALE, FIN, ERR.
REQ-018 IDLE: if any req bit is high, SHALL latch the winner and req_sel[winner] and go to LAUNCH next cycle; otherwise SHALL stay in IDLE.
REQ-019 Arbitration SHALL be round-robin: with both bits high, the requester not served last wins; after reset, requester 0 has priority.
REQ-020 LAUNCH: ag_start=1 and gnt[winner]=1 for exactly one cycle; SHALL then go to RUN.
REQ-021 RUN: SHALL clear the timeout counter on entry and increment it each cycle.
REQ-022 RUN: ag_done=1 SHALL go to FIN if sel=0, or to SCALE if sel=1.
REQ-023 RUN: counter reaching TIMEOUT-1 without ag_done SHALL go to ERR.
REQ-024 SCALE: scale_en=1 and scale_addr starts at 0, increments by 1 per cycle, and ends at N-1 (exactly N cycles); SHALL then go to FIN.
REQ-025 Outside SCALE, scale_en=0 and scale_addr=0.
REQ-026 FIN: job_done[winner]=1 for one cycle, then IDLE; gnt SHALL drop on entry to IDLE.
REQ-027 ERR: job_done[winner]=1 and job_err=1 for one cycle, then IDLE.
REQ-028 gnt[winner] SHALL stay high from LAUNCH through FIN/ERR inclusive.
REQ-029 Deassertion of req mid-job SHALL be ignored; the job runs to completion.
REQ-030 Changes to req_sel after grant SHALL be ignored.
REQ-031 ag_done outside RUN, including in the LAUNCH cycle, SHALL be ignored.
REQ-032 A requester SHALL drop req in the cycle after job_done; req high in IDLE SHALL count as a new job.
REQ-033 Latency: req high at edge k gives ag_start at edge k+1; ag_done at edge d gives NTT job_done at d+1, or INTT job_done at d+N+1.

Reset
REQ-034 While rst=0, SHALL force state IDLE and gnt=0, busy=0, ag_start=0, ag_sel=0, scale_en=0, scale_addr=0, job_done=0, job_err=0, timeout counter=0, round-robin pointer=requester 0.
REQ-035 Reset asserted mid-job SHALL abort the job without a job_done pulse.
REQ-036 The first job after reset release SHALL arbitrate normally.

Verification
REQ-037 Single NTT: req=01, req_sel=00, stub done 896 cycles after start -> gnt=01, one ag_start with ag_sel=0, job_done=01 one cycle after ag_done, scale_en never high.
REQ-038 Single INTT: req=10, req_sel=10 -> ag_sel=1; after ag_done, scale_addr runs 0..255 over 256 cycles; job_done=10 on the next cycle.
REQ-039 Contention: req=11 held, each requester re-raising req after its job_done -> grant order 01,10,01,10; never two bits of gnt high.
REQ-040 Timeout: stub never asserts done -> job_err=1 with job_done on the 2048th RUN cycle, then IDLE; the next req is served normally.
REQ-041 Spurious/abort: ag_done pulsed in IDLE -> no state change; rst=0 in SCALE at scale_addr=100 -> all outputs 0 immediately and no job_done.
REQ-042 Mid-job change: req_sel and req toggled during RUN -> ag_sel constant and the job completes with exactly one job_done.
